core_bus_arbiter: RTL and testbench

Merges the core's instruction bus (ibus) and data bus (dbus) onto one single-beat memory bus (cbus) in front of the memory/cache side. It sits directly downstream of the pipelined core, consuming its `ireq`/`dreq` outputs and producing the `iresp`/`dresp` handshakes that the fetch stall (`stallpc`) and the memory-stage stall (`stallM`) depend on. One transaction is outstanding at a time, and dbus has priority over ibus.

---
 rtl/core_bus_arbiter.sv | 139 +++++++++++++
 tb/tb_core_bus_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_bus_arbiter.sv
// core_bus_arbiter: merges ibus and dbus onto one single-beat cbus, dbus first, one transaction in flight
module core_bus_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ireq_valid,
    input  logic [ADDR_W-1:0] ireq_addr,
    output logic              iresp_addr_ok,
    output logic              iresp_data_ok,
    output logic [31:0]       iresp_data,
    input  logic              dreq_valid,
    input  logic [ADDR_W-1:0] dreq_addr,
    input  logic [2:0]        dreq_size,
    input  logic [7:0]        dreq_strobe,
    input  logic [DATA_W-1:0] dreq_data,
    output logic              dresp_addr_ok,
    output logic              dresp_data_ok,
    output logic [DATA_W-1:0] dresp_data,
    output logic              creq_valid,
    output logic              creq_is_write,
    output logic [2:0]        creq_size,
    output logic [ADDR_W-1:0] creq_addr,
    output logic [7:0]        creq_strobe,
    output logic [DATA_W-1:0] creq_data,
    input  logic              cresp_ready,
    input  logic [DATA_W-1:0] cresp_data
);

    typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        size_q, size_d;
    logic [7:0]        strobe_q, strobe_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              is_write_q, is_write_d;

    // state register plus latched request and captured response
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            size_q     <= '0;
            strobe_q   <= '0;
            data_q     <= '0;
            rdata_q    <= '0;
            is_write_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            strobe_q   <= strobe_d;
            data_q     <= data_d;
            rdata_q    <= rdata_d;
            is_write_q <= is_write_d;
        end
    end

    // arbitration: only IDLE accepts requests, dbus wins ties, BUSY waits for the memory pulse
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        size_d     = size_q;
        strobe_d   = strobe_q;
        data_d     = data_q;
        rdata_d    = rdata_q;
        is_write_d = is_write_q;
        case (state_q)
            IDLE: begin
                if (dreq_valid) begin
                    addr_d     = dreq_addr;
                    size_d     = dreq_size;
                    strobe_d   = dreq_strobe;
                    data_d     = dreq_data;
                    is_write_d = |dreq_strobe;
                    state_d    = BUSY_D;
                end else if (ireq_valid) begin
                    addr_d     = ireq_addr;
                    size_d     = 3'b010;
                    strobe_d   = 8'h00;
                    data_d     = '0;
                    is_write_d = 1'b0;
                    state_d    = BUSY_I;
                end
            end
            BUSY_I: begin
                if (cresp_ready) begin
                    rdata_d = cresp_data;
                    state_d = RESP_I;
                end
            end
            BUSY_D: begin
                if (cresp_ready) begin
                    rdata_d = cresp_data;
                    state_d = RESP_D;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // outputs are zero except in the state that owns them
    always_comb begin
        creq_valid    = 1'b0;
        creq_is_write = 1'b0;
        creq_size     = '0;
        creq_addr     = '0;
        creq_strobe   = '0;
        creq_data     = '0;
        iresp_addr_ok = 1'b0;
        iresp_data_ok = 1'b0;
        iresp_data    = '0;
        dresp_addr_ok = 1'b0;
        dresp_data_ok = 1'b0;
        dresp_data    = '0;
        if (state_q == BUSY_I || state_q == BUSY_D) begin
            creq_valid    = 1'b1;
            creq_is_write = is_write_q;
            creq_size     = size_q;
            creq_addr     = addr_q;
            creq_strobe   = strobe_q;
            creq_data     = data_q;
        end
        if (state_q == RESP_I) begin
            iresp_addr_ok = 1'b1;
            iresp_data_ok = 1'b1;
            iresp_data    = addr_q[2] ? rdata_q[63:32] : rdata_q[31:0];
        end
        if (state_q == RESP_D) begin
            dresp_addr_ok = 1'b1;
            dresp_data_ok = 1'b1;
            dresp_data    = is_write_q ? '0 : rdata_q;
        end
    end

endmodule

// File: tb/tb_core_bus_arbiter.sv
// tb_core_bus_arbiter: directed scenario checks for core_bus_arbiter
module tb_core_bus_arbiter;

    logic        clk;
    logic        reset;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_addr_ok;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic        dreq_valid;
    logic [63:0] dreq_addr;
    logic [2:0]  dreq_size;
    logic [7:0]  dreq_strobe;
    logic [63:0] dreq_data;
    logic        dresp_addr_ok;
    logic        dresp_data_ok;
    logic [63:0] dresp_data;
    logic        creq_valid;
    logic        creq_is_write;
    logic [2:0]  creq_size;
    logic [63:0] creq_addr;
    logic [7:0]  creq_strobe;
    logic [63:0] creq_data;
    logic        cresp_ready;
    logic [63:0] cresp_data;
    logic [240:0] all_out;
    int total;
    int bad;

    core_bus_arbiter dut (
        .clk(clk), .reset(reset),
        .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
        .iresp_addr_ok(iresp_addr_ok), .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
        .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
        .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
        .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
        .creq_valid(creq_valid), .creq_is_write(creq_is_write), .creq_size(creq_size),
        .creq_addr(creq_addr), .creq_strobe(creq_strobe), .creq_data(creq_data),
        .cresp_ready(cresp_ready), .cresp_data(cresp_data)
    );

    assign all_out = {creq_valid, creq_is_write, creq_size, creq_addr, creq_strobe, creq_data,
                      iresp_addr_ok, iresp_data_ok, iresp_data, dresp_addr_ok, dresp_data_ok, dresp_data};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        tick;
        tick;
        total++;
        if (all_out !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=0", all_out);
        end
        reset = 1'b1;
        dreq_valid = 1'b1;
        dreq_addr = 64'h8000_0010;
        dreq_size = 3'd3;
        dreq_strobe = 8'h00;
        tick;
        total++;
        if ({creq_valid, creq_addr} !== {1'b1, 64'h8000_0010}) begin
            bad++;
            $display("FAIL reset_busy_d got=%b/%h want=1/8000000000000010", creq_valid, creq_addr);
        end
        #2;
        reset = 1'b0;
        dreq_valid = 1'b0;
        #1;
        total++;
        if (all_out !== '0) begin
            bad++;
            $display("FAIL reset_async got=%h want=0", all_out);
        end
        tick;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            total++;
            if (all_out !== '0) begin
                bad++;
                $display("FAIL reset_idle_after cyc=%0d got=%h want=0", i, all_out);
            end
        end
    endtask

    task automatic test_fetch(input logic [63:0] a, input logic [31:0] exp);
        ireq_valid = 1'b1;
        ireq_addr = a;
        tick;
        total++;
        if ({creq_valid, creq_is_write, creq_size, creq_strobe, creq_addr} !== {1'b1, 1'b0, 3'd2, 8'h00, a}) begin
            bad++;
            $display("FAIL fetch_creq got=%b %b %0d %h %h want=1 0 2 00 %h",
                     creq_valid, creq_is_write, creq_size, creq_strobe, creq_addr, a);
        end
        tick;
        tick;
        total++;
        if (iresp_data_ok !== 1'b0 || creq_valid !== 1'b1) begin
            bad++;
            $display("FAIL fetch_early got ok=%b valid=%b want ok=0 valid=1", iresp_data_ok, creq_valid);
        end
        cresp_ready = 1'b1;
        cresp_data = 64'h1111_2222_3333_4444;
        tick;
        cresp_ready = 1'b0;
        cresp_data = 64'h0;
        total++;
        if ({iresp_addr_ok, iresp_data_ok, iresp_data, creq_valid} !== {1'b1, 1'b1, exp, 1'b0}) begin
            bad++;
            $display("FAIL fetch_resp got=%b %b %h %b want=1 1 %h 0",
                     iresp_addr_ok, iresp_data_ok, iresp_data, creq_valid, exp);
        end
        ireq_valid = 1'b0;
        tick;
        total++;
        if (all_out !== '0) begin
            bad++;
            $display("FAIL fetch_after got=%h want=0", all_out);
        end
    endtask

    task automatic test_simultaneous;
        ireq_valid = 1'b1;
        ireq_addr = 64'h8000_0000;
        dreq_valid = 1'b1;
        dreq_addr = 64'h8000_1000;
        dreq_size = 3'd3;
        dreq_strobe = 8'h00;
        dreq_data = 64'h0;
        tick;
        total++;
        if ({creq_valid, creq_is_write, creq_addr, creq_size} !== {1'b1, 1'b0, 64'h8000_1000, 3'd3}) begin
            bad++;
            $display("FAIL sim_d_first got=%b %b %h %0d want=1 0 8000000000001000 3",
                     creq_valid, creq_is_write, creq_addr, creq_size);
        end
        cresp_ready = 1'b1;
        cresp_data = 64'hAAAA_BBBB_CCCC_DDDD;
        tick;
        cresp_ready = 1'b0;
        total++;
        if ({dresp_data_ok, dresp_addr_ok, dresp_data, iresp_data_ok} !== {1'b1, 1'b1, 64'hAAAA_BBBB_CCCC_DDDD, 1'b0}) begin
            bad++;
            $display("FAIL sim_d_resp got=%b %b %h iok=%b want=1 1 aaaabbbbccccdddd iok=0",
                     dresp_data_ok, dresp_addr_ok, dresp_data, iresp_data_ok);
        end
        dreq_valid = 1'b0;
        tick;
        total++;
        if ({creq_valid, iresp_data_ok, dresp_data_ok} !== 3'b000) begin
            bad++;
            $display("FAIL sim_gap got=%b%b%b want=000", creq_valid, iresp_data_ok, dresp_data_ok);
        end
        tick;
        total++;
        if ({creq_valid, creq_addr, iresp_data_ok} !== {1'b1, 64'h8000_0000, 1'b0}) begin
            bad++;
            $display("FAIL sim_i_next got=%b %h %b want=1 8000000000000000 0", creq_valid, creq_addr, iresp_data_ok);
        end
        cresp_ready = 1'b1;
        cresp_data = 64'h5555_6666_7777_8888;
        tick;
        cresp_ready = 1'b0;
        total++;
        if ({iresp_data_ok, iresp_data} !== {1'b1, 32'h7777_8888}) begin
            bad++;
            $display("FAIL sim_i_resp got=%b %h want=1 77778888", iresp_data_ok, iresp_data);
        end
        ireq_valid = 1'b0;
        tick;
    endtask

    task automatic test_store;
        dreq_valid = 1'b1;
        dreq_addr = 64'h8000_2000;
        dreq_size = 3'd2;
        dreq_strobe = 8'h0F;
        dreq_data = 64'hDEAD_BEEF;
        tick;
        total++;
        if ({creq_valid, creq_is_write, creq_strobe, creq_size, creq_data, creq_addr} !==
            {1'b1, 1'b1, 8'h0F, 3'd2, 64'hDEAD_BEEF, 64'h8000_2000}) begin
            bad++;
            $display("FAIL store_creq got=%b %b %h %0d %h %h want=1 1 0f 2 deadbeef 80002000",
                     creq_valid, creq_is_write, creq_strobe, creq_size, creq_data, creq_addr);
        end
        cresp_ready = 1'b1;
        cresp_data = 64'hFFFF_FFFF_FFFF_FFFF;
        tick;
        cresp_ready = 1'b0;
        total++;
        if ({dresp_data_ok, dresp_data} !== {1'b1, 64'h0}) begin
            bad++;
            $display("FAIL store_resp got=%b %h want=1 0", dresp_data_ok, dresp_data);
        end
        dreq_valid = 1'b0;
        dreq_strobe = 8'h00;
        tick;
        total++;
        if (dresp_data_ok !== 1'b0) begin
            bad++;
            $display("FAIL store_once got=%b want=0", dresp_data_ok);
        end
    endtask

    task automatic test_busy_changes;
        ireq_valid = 1'b1;
        ireq_addr = 64'h8000_0100;
        tick;
        for (int i = 0; i < 3; i++) begin
            ireq_addr = 64'h9000_0004 + 64'(i * 8);
            tick;
            total++;
            if ({creq_valid, creq_addr} !== {1'b1, 64'h8000_0100}) begin
                bad++;
                $display("FAIL busy_hold cyc=%0d got=%b %h want=1 8000000000000100", i, creq_valid, creq_addr);
            end
        end
        cresp_ready = 1'b1;
        cresp_data = 64'h0102_0304_0506_0708;
        tick;
        cresp_ready = 1'b0;
        total++;
        if ({iresp_data_ok, iresp_data} !== {1'b1, 32'h0506_0708}) begin
            bad++;
            $display("FAIL busy_resp got=%b %h want=1 05060708", iresp_data_ok, iresp_data);
        end
        ireq_valid = 1'b0;
        tick;
        cresp_ready = 1'b1;
        cresp_data = 64'hCAFE_CAFE_CAFE_CAFE;
        tick;
        cresp_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            total++;
            if (all_out !== '0) begin
                bad++;
                $display("FAIL spurious_ready cyc=%0d got=%h want=0", i, all_out);
            end
            tick;
        end
    endtask

    task automatic test_stream;
        logic exp_ok;
        ireq_valid = 1'b1;
        ireq_addr = 64'h8000_0000;
        cresp_data = 64'h1234_5678_9ABC_DEF0;
        for (int i = 1; i <= 12; i++) begin
            tick;
            cresp_ready = creq_valid;
            exp_ok = (i % 3 == 2);
            total++;
            if ({iresp_data_ok, iresp_addr_ok, iresp_data} !== {exp_ok, exp_ok, exp_ok ? 32'h9ABC_DEF0 : 32'h0}) begin
                bad++;
                $display("FAIL stream cyc=%0d got=%b %b %h want=%b %b", i, iresp_data_ok, iresp_addr_ok, iresp_data, exp_ok, exp_ok);
            end
        end
        ireq_valid = 1'b0;
        cresp_ready = 1'b0;
        tick;
        tick;
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset = 1'b0;
        ireq_valid = 1'b0;
        ireq_addr = '0;
        dreq_valid = 1'b0;
        dreq_addr = '0;
        dreq_size = '0;
        dreq_strobe = '0;
        dreq_data = '0;
        cresp_ready = 1'b0;
        cresp_data = '0;
        test_reset;
        test_fetch(64'h8000_0004, 32'h1111_2222);
        test_fetch(64'h8000_0000, 32'h3333_4444);
        test_simultaneous;
        test_store;
        test_busy_changes;
        test_stream;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
